ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits between the ID/EX decode outputs and the memory stage.
- Performs ALU operations and a 32-iteration multiply/divide unit with HI/LO registers.
- Drives the registered EX/MEM outputs that feed the memory stage: writeback control, memory-write strobe, ALU result used as data address, store data, destination register.
- Stalls upstream while a multiply/divide is in flight.

---
 rtl/ex_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage MIPS pipeline. Computes the ALU result for the
// instruction sitting in ID/EX, runs an iterative multiply/divide unit that
// owns the HI/LO registers, and drives the registered EX/MEM outputs.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wbi, mi               writeback control / memory-write strobe from decode
//   aluop                 operation select
//   alusrc                1: operand B = imm, 0: operand B = rtdata
//   regdst                1: destination = rd, 0: destination = rt
//   rsdata, rtdata, imm   operands; imm[10:6] is the shift amount
//   rt, rd                register numbers
//   stall                 combinational, upstream holds its inputs while high
//   wbo, mo, aluresult,   registered EX/MEM outputs to the memory stage
//   storedata, regaddrout
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   wbi,
    input  logic         mi,
    input  logic [4:0]   aluop,
    input  logic         alusrc,
    input  logic         regdst,
    input  logic [W-1:0] rsdata,
    input  logic [W-1:0] rtdata,
    input  logic [W-1:0] imm,
    input  logic [4:0]   rt,
    input  logic [4:0]   rd,
    output logic         stall,
    output logic [1:0]   wbo,
    output logic         mo,
    output logic [W-1:0] aluresult,
    output logic [W-1:0] storedata,
    output logic [4:0]   regaddrout
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mdState_e;

    mdState_e       state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]   accHi_q, accHi_d, accLo_q, accLo_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [W-1:0]   dividend_q, dividend_d;
    logic           isDiv_q, isDiv_d;
    logic           negQ_q, negQ_d;
    logic           negR_q, negR_d;
    logic           divZero_q, divZero_d;

    logic [1:0]     wbo_q;
    logic           mo_q;
    logic [W-1:0]   aluresult_q, storedata_q;
    logic [4:0]     regaddrout_q;

    logic [W-1:0]   opB;
    logic [4:0]     shamt;
    logic [W-1:0]   result;
    logic           isMulDiv, mdSigned, mdDiv;
    logic           aNeg, bNeg;
    logic [W-1:0]   aMag, bMag;
    logic [W:0]     mulSum;
    logic [W:0]     divShift;
    logic           divFits;
    logic [W-1:0]   divDiff;
    logic [W-1:0]   stepHi, stepLo;
    logic [2*W-1:0] prodFix;
    logic           mdStall;

    assign opB      = alusrc ? imm : rtdata;
    assign shamt    = imm[10:6];
    assign isMulDiv = (aluop >= 5'd12) && (aluop <= 5'd15);
    assign mdSigned = (aluop == 5'd12) || (aluop == 5'd14);
    assign mdDiv    = (aluop == 5'd14) || (aluop == 5'd15);

    // Signed forms iterate on magnitudes; the sign is reapplied at the end.
    assign aNeg = mdSigned & rsdata[W-1];
    assign bNeg = mdSigned & opB[W-1];
    assign aMag = aNeg ? -rsdata : rsdata;
    assign bMag = bNeg ? -opB : opB;

    // Multiply: accLo holds the multiplier, consumed from bit 0 while the
    // partial product shifts in from the top.
    assign mulSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});

    // Divide: accHi is the partial remainder, quotient bits enter accLo at
    // bit 0 as dividend bits leave from the top. The remainder is always
    // below the divisor, so a W-bit subtraction is exact when it is taken.
    assign divShift = {accHi_q, accLo_q[W-1]};
    assign divFits  = divShift >= {1'b0, mag_q};
    assign divDiff  = divShift[W-1:0] - mag_q;

    assign stepHi  = isDiv_q ? (divFits ? divDiff : divShift[W-1:0]) : mulSum[W:1];
    assign stepLo  = isDiv_q ? {accLo_q[W-2:0], divFits} : {mulSum[0], accLo_q[W-1:1]};
    assign prodFix = negQ_q ? -{stepHi, stepLo} : {stepHi, stepLo};

    // ALU result select; mul/div codes produce no result of their own.
    always_comb begin
        result = '0;
        case (aluop)
            5'd0:    result = rsdata + opB;
            5'd1:    result = rsdata - opB;
            5'd2:    result = rsdata & opB;
            5'd3:    result = rsdata | opB;
            5'd4:    result = rsdata ^ opB;
            5'd5:    result = ~(rsdata | opB);
            5'd6:    result = {{(W-1){1'b0}}, ($signed(rsdata) < $signed(opB))};
            5'd7:    result = {{(W-1){1'b0}}, (rsdata < opB)};
            5'd8:    result = opB << shamt;
            5'd9:    result = opB >> shamt;
            5'd10:   result = $signed(opB) >>> shamt;
            5'd11:   result = opB << 16;
            5'd16:   result = hi_q;
            5'd17:   result = lo_q;
            default: result = '0;
        endcase
    end

    // Multiply/divide sequencer. DONE lets the instruction leave and always
    // returns to IDLE, so a mul/div code still on aluop cannot retrigger.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        accHi_d    = accHi_q;
        accLo_d    = accLo_q;
        mag_d      = mag_q;
        dividend_d = dividend_q;
        isDiv_d    = isDiv_q;
        negQ_d     = negQ_q;
        negR_d     = negR_q;
        divZero_d  = divZero_q;
        mdStall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (isMulDiv) begin
                    mdStall    = 1'b1;
                    state_d    = BUSY;
                    cnt_d      = '0;
                    accHi_d    = '0;
                    accLo_d    = aMag;
                    mag_d      = bMag;
                    dividend_d = rsdata;
                    isDiv_d    = mdDiv;
                    negQ_d     = aNeg ^ bNeg;
                    negR_d     = aNeg;
                    divZero_d  = mdDiv && (opB == '0);
                end
            end
            BUSY: begin
                mdStall = 1'b1;
                accHi_d = stepHi;
                accLo_d = stepLo;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    state_d = DONE;
                    if (divZero_q) begin
                        hi_d = dividend_q;
                        lo_d = '1;
                    end else if (isDiv_q) begin
                        lo_d = negQ_q ? -stepLo : stepLo;
                        hi_d = negR_q ? -stepHi : stepHi;
                    end else begin
                        hi_d = prodFix[2*W-1:W];
                        lo_d = prodFix[W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall = mdStall & ~reset;

    // Sequencer state and HI/LO; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            accHi_q    <= '0;
            accLo_q    <= '0;
            mag_q      <= '0;
            dividend_q <= '0;
            isDiv_q    <= 1'b0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            divZero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            accHi_q    <= accHi_d;
            accLo_q    <= accLo_d;
            mag_q      <= mag_d;
            dividend_q <= dividend_d;
            isDiv_q    <= isDiv_d;
            negQ_q     <= negQ_d;
            negR_q     <= negR_d;
            divZero_q  <= divZero_d;
        end
    end

    // EX/MEM register: bubbles while stalled; mul/div never writes the GPR
    // file or memory, so their control strobes are suppressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbo_q        <= '0;
            mo_q         <= 1'b0;
            aluresult_q  <= '0;
            storedata_q  <= '0;
            regaddrout_q <= '0;
        end else if (stall) begin
            wbo_q        <= '0;
            mo_q         <= 1'b0;
            aluresult_q  <= '0;
            storedata_q  <= '0;
            regaddrout_q <= '0;
        end else begin
            wbo_q        <= isMulDiv ? 2'b00 : wbi;
            mo_q         <= isMulDiv ? 1'b0 : mi;
            aluresult_q  <= result;
            storedata_q  <= rtdata;
            regaddrout_q <= regdst ? rd : rt;
        end
    end

    assign wbo        = wbo_q;
    assign mo         = mo_q;
    assign aluresult  = aluresult_q;
    assign storedata  = storedata_q;
    assign regaddrout = regaddrout_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
// Scoreboard bench for ex_stage: the driver pushes one expected EX/MEM record
// per clock edge, a monitor pops and compares it just after the edge.
// Expected values come from a reference model using plain 64-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wbi;
    logic        mi;
    logic [4:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic [31:0] rsdata, rtdata, imm;
    logic [4:0]  rt, rd;
    logic        stall;
    logic [1:0]  wbo;
    logic        mo;
    logic [31:0] aluresult, storedata;
    logic [4:0]  regaddrout;

    ex_stage #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wbi        (wbi),
        .mi         (mi),
        .aluop      (aluop),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .rsdata     (rsdata),
        .rtdata     (rtdata),
        .imm        (imm),
        .rt         (rt),
        .rd         (rd),
        .stall      (stall),
        .wbo        (wbo),
        .mo         (mo),
        .aluresult  (aluresult),
        .storedata  (storedata),
        .regaddrout (regaddrout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wbi;
        logic        mi;
        logic [4:0]  aluop;
        logic        alusrc;
        logic        regdst;
        logic [31:0] rsdata;
        logic [31:0] rtdata;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic [1:0]  wbo;
        logic        mo;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  dst;
        bit          ctlOnly;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          vecCnt = 0;
    int          missCnt = 0;
    logic [31:0] hiM = '0;
    logic [31:0] loM = '0;

    function automatic instr_t mk(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] im,
                                  input logic src, input logic [1:0] wb, input logic m);
        instr_t i;
        i.wbi = wb; i.mi = m; i.aluop = op; i.alusrc = src; i.regdst = 1'b1;
        i.rsdata = a; i.rtdata = b; i.imm = im; i.rt = 5'd2; i.rd = 5'd3;
        return i;
    endfunction

    // Reference ALU: the architectural meaning of each opcode.
    function automatic logic [31:0] aluRef(input instr_t i);
        logic [31:0] a, b;
        int unsigned sh;
        a  = i.rsdata;
        b  = i.alusrc ? i.imm : i.rtdata;
        sh = int'(i.imm[10:6]);
        case (i.aluop)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return b << sh;
            5'd9:  return b >> sh;
            5'd10: return 32'(int'(b) >>> sh);
            5'd11: return {b[15:0], 16'h0000};
            5'd16: return hiM;
            5'd17: return loM;
            default: return 32'd0;
        endcase
    endfunction

    // Reference HI/LO update using 64-bit host arithmetic.
    task automatic mdRef(input instr_t i);
        logic [31:0] a, b;
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        a = i.rsdata;
        b = i.alusrc ? i.imm : i.rtdata;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (i.aluop)
            5'd12: begin p = 64'(sa * sb); hiM = p[63:32]; loM = p[31:0]; end
            5'd13: begin p = {32'd0, a} * {32'd0, b}; hiM = p[63:32]; loM = p[31:0]; end
            5'd14: begin
                if (b == 32'd0) begin hiM = a; loM = 32'hFFFF_FFFF; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    p = 64'(sq); loM = p[31:0];
                    p = 64'(sr); hiM = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin hiM = a; loM = 32'hFFFF_FFFF; end
                else begin loM = a / b; hiM = a % b; end
            end
        endcase
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vecCnt++;
        if (act !== expv) begin
            missCnt++;
            $display("[TB] FAIL %s: got %h, want %h", nm, act, expv);
        end
    endtask

    task automatic driveInstr(input instr_t ins);
        wbi = ins.wbi; mi = ins.mi; aluop = ins.aluop; alusrc = ins.alusrc;
        regdst = ins.regdst; rsdata = ins.rsdata; rtdata = ins.rtdata;
        imm = ins.imm; rt = ins.rt; rd = ins.rd;
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic doReset(input string nm);
        #1 reset = 1'b1;
        #1;
        checkOutput({nm, " stall"}, {31'd0, stall}, 32'd0);
        checkOutput({nm, " wbo"}, {30'd0, wbo}, 32'd0);
        checkOutput({nm, " mo"}, {31'd0, mo}, 32'd0);
        checkOutput({nm, " aluresult"}, aluresult, 32'd0);
        checkOutput({nm, " storedata"}, storedata, 32'd0);
        checkOutput({nm, " regaddrout"}, {27'd0, regaddrout}, 32'd0);
        sbq.delete();
        hiM = '0;
        loM = '0;
        driveInstr(mk(5'd18, '0, '0, '0, 1'b0, 2'b00, 1'b0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Holds one instruction until it leaves EX, queueing one expectation per
    // edge. abortAt > 0 asserts reset after that many stalled edges.
    task automatic applyStimulus(input instr_t ins, input string nm, input int abortAt);
        int   stalls;
        bit   s;
        bit   md;
        exp_t e;
        stalls = 0;
        md = (ins.aluop >= 5'd12) && (ins.aluop <= 5'd15);
        driveInstr(ins);
        while (1) begin
            @(negedge clk);
            if (abortAt > 0 && stalls == abortAt) begin
                doReset({nm, " abort"});
                return;
            end
            s = stall;
            @(posedge clk);
            if (s) begin
                stalls++;
                e = '{wbo: 2'b00, mo: 1'b0, alu: '0, store: '0, dst: '0,
                      ctlOnly: 1'b0, name: {nm, " bubble"}};
                sbq.push_back(e);
                if (stalls > 100) begin
                    checkOutput({nm, " stall timeout"}, stalls, 32'd33);
                    break;
                end
            end else begin
                if (md) begin
                    e = '{wbo: 2'b00, mo: 1'b0, alu: '0, store: '0, dst: '0,
                          ctlOnly: 1'b1, name: {nm, " exit"}};
                    mdRef(ins);
                end else begin
                    e = '{wbo: ins.wbi, mo: ins.mi, alu: aluRef(ins), store: ins.rtdata,
                          dst: ins.regdst ? ins.rd : ins.rt, ctlOnly: 1'b0, name: nm};
                end
                sbq.push_back(e);
                break;
            end
        end
        checkOutput({nm, " stall cycles"}, stalls, md ? 32'd33 : 32'd0);
        #1;
    endtask

    // Monitor: compares the registered outputs just after each edge.
    always @(posedge clk) begin
        exp_t e;
        bit   ok;
        #1;
        if (!reset && sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.ctlOnly)
                ok = (wbo === e.wbo) && (mo === e.mo);
            else
                ok = (wbo === e.wbo) && (mo === e.mo) && (aluresult === e.alu) &&
                     (storedata === e.store) && (regaddrout === e.dst);
            vecCnt++;
            if (!ok) begin
                missCnt++;
                $display("[TB] FAIL %s: got wbo=%b mo=%b alu=%h st=%h dst=%0d, want wbo=%b mo=%b alu=%h st=%h dst=%0d",
                         e.name, wbo, mo, aluresult, storedata, regaddrout,
                         e.wbo, e.mo, e.alu, e.store, e.dst);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t ins;
        int     r;
        reset = 1'b1;
        driveInstr(mk(5'd18, '0, '0, '0, 1'b0, 2'b00, 1'b0));
        #1;
        checkOutput("power-on stall", {31'd0, stall}, 32'd0);
        checkOutput("power-on aluresult", aluresult, 32'd0);
        checkOutput("power-on wbo", {30'd0, wbo}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        applyStimulus(mk(5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 2'b11, 1'b0), "ADD 5+7", 0);
        doReset("mid-cycle reset");

        applyStimulus(mk(5'd1, 32'd3, 32'd5, 32'd0, 1'b0, 2'b10, 1'b0), "SUB 3-5", 0);
        applyStimulus(mk(5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b10, 1'b0), "SLT -1,1", 0);
        applyStimulus(mk(5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b10, 1'b0), "SLTU -1,1", 0);
        applyStimulus(mk(5'd10, 32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0, 2'b10, 1'b0), "SRA sh4", 0);
        applyStimulus(mk(5'd11, 32'd0, 32'd0, 32'h0000_1234, 1'b1, 2'b10, 1'b0), "LUI", 0);
        applyStimulus(mk(5'd0, 32'h0000_1000, 32'hCAFE_BABE, 32'h0000_0010, 1'b1, 2'b00, 1'b1), "store", 0);

        applyStimulus(mk(5'd12, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 2'b11, 1'b1), "MULT -3*7", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after MULT", 0);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after MULT", 0);
        applyStimulus(mk(5'd13, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b11, 1'b0), "MULTU", 0);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after MULTU", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after MULTU", 0);
        applyStimulus(mk(5'd14, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 2'b11, 1'b0), "DIV -7/2", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after DIV", 0);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after DIV", 0);
        applyStimulus(mk(5'd15, 32'd7, 32'd0, 32'd0, 1'b0, 2'b11, 1'b0), "DIVU 7/0", 0);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after DIVU/0", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after DIVU/0", 0);
        applyStimulus(mk(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b11, 1'b0), "DIV min/-1", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after DIV min", 0);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after DIV min", 0);

        applyStimulus(mk(5'd12, 32'd5, 32'd9, 32'd0, 1'b0, 2'b11, 1'b0), "MULT aborted", 10);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after abort", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after abort", 0);
        applyStimulus(mk(5'd12, 32'd2, 32'd3, 32'd0, 1'b0, 2'b11, 1'b0), "MULT 2*3", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after MULT 2*3", 0);

        applyStimulus(mk(5'd15, 32'd100, 32'd7, 32'd0, 1'b0, 2'b11, 1'b0), "DIVU 100/7", 0);
        applyStimulus(mk(5'd16, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFHI after DIVU", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after DIVU", 0);
        applyStimulus(mk(5'd15, 32'd100, 32'd7, 32'd0, 1'b0, 2'b11, 1'b0), "DIVU 100/7 b2b", 0);
        applyStimulus(mk(5'd13, 32'd4, 32'd5, 32'd0, 1'b0, 2'b11, 1'b0), "MULTU 4*5 b2b", 0);
        applyStimulus(mk(5'd17, '0, '0, '0, 1'b0, 2'b10, 1'b0), "MFLO after MULTU 4*5", 0);

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 31));
            if (r >= 12 && r <= 15 && $urandom_range(0, 3) != 0)
                r = r - 12;
            ins.aluop  = 5'(r);
            ins.wbi    = 2'($urandom_range(0, 3));
            ins.mi     = 1'($urandom_range(0, 1));
            ins.alusrc = 1'($urandom_range(0, 1));
            ins.regdst = 1'($urandom_range(0, 1));
            ins.rsdata = $urandom;
            ins.rtdata = $urandom;
            ins.imm    = $urandom;
            ins.rt     = 5'($urandom_range(0, 31));
            ins.rd     = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) begin
                ins.rtdata = '0;
                ins.imm    = '0;
            end
            applyStimulus(ins, $sformatf("random #%0d op%0d", n, r), 0);
        end

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
